btn_debouncer: RTL and testbench
================================

# btn_debouncer

Debounces and synchronises the five board push-buttons before they reach the game logic. It sits between the raw button pins and `block_controller`, and replaces the direct `BtnU/BtnD/BtnL/BtnR/BtnC` connections. Each channel produces three outputs: a clean level, a one-cycle press pulse with optional hold-to-repeat, and a one-cycle release pulse. All channels are independent and share one clock.

## Interface

Parameters:
- `N_BTN`, 5: number of button channels. Index map: 0=C, 1=U, 2=D, 3=L, 4=R.
- `DEB_CYC`, 1048576: number of cycles an input must stay stable to be accepted (about 10.5 ms at 100 MHz). Must be ≥ 2.
- `HOLD_CYC`, 50000000: cycles from the press pulse to the first repeat pulse.
- `REP_CYC`, 10000000: cycles between subsequent repeat pulses.
- `REPEAT_EN`, 1: 1 enables hold-to-repeat; 0 gives press pulses only.

Ports:
- `clk` in 1: system clock, 100 MHz `ClkPort`.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_raw` in N_BTN: raw asynchronous button pins, active-high.
- `btn_level` out N_BTN: debounced level.
- `btn_press` out N_BTN: one-cycle pulse on an accepted press and on each repeat.
- `btn_release` out N_BTN: one-cycle pulse on an accepted release.

## Operation

- **Synchroniser.** Each channel passes through a 2-FF synchroniser; its output is `s`.
- **Per-channel FSM.** States are IDLE, DEB_PRESS, HELD and DEB_REL. Each channel has a debounce counter `cnt` and a repeat counter `rcnt` with a `first_done` flag. Counter widths are `$clog2` of the largest relevant parameter.
- **IDLE.** `level`=0. If `s`=1: go to DEB_PRESS with `cnt`=0.
- **DEB_PRESS.** `level`=0.
  - If `s`=0: return to IDLE. No pulse is produced.
  - Otherwise `cnt`++. At the edge where `cnt`==DEB_CYC-1: go to HELD, set `rcnt`=0 and `first_done`=0, and register a press pulse.
- **HELD.** `level`=1.
  - If `s`=0: go to DEB_REL with `cnt`=0.
  - Otherwise, when REPEAT_EN=1, `rcnt`++. Emit a repeat pulse (on `btn_press`) at `rcnt`==HOLD_CYC-1 while `first_done`=0, and at `rcnt`==REP_CYC-1 while `first_done`=1. On each repeat pulse set `rcnt`=0 and `first_done`=1.
- **DEB_REL.** `level` stays 1 and no repeats are produced.
  - If `s`=1: return to HELD with `rcnt`=0 and `first_done`=0 (the repeat timer restarts).
  - Otherwise `cnt`++. At `cnt`==DEB_CYC-1: go to IDLE and register a release pulse.
- **Outputs.** All outputs are registered. `btn_level` is high exactly when the state is HELD or DEB_REL.
- **Pulse overlap.** A press pulse and a release pulse are never high in the same cycle on the same channel. Different channels may pulse in the same cycle.
- **Reset.** Asserting `rst_n` low at any time immediately sets all states to IDLE and all counters, synchronisers and outputs to 0. After release, a button that is still held is treated as a new press and is debounced again.

## Timing

- **Reset values.** `btn_level`, `btn_press`, `btn_release` = 0.
- **Press latency.**
  - Edge E1 is the first rising edge that samples `btn_raw` high.
  - `btn_level` and `btn_press` rise after edge E(DEB_CYC+3).
  - `btn_press` is high for exactly 1 cycle.
- **Release latency.**
  - Edge E1 is the first rising edge that samples `btn_raw` low.
  - `btn_level` falls, and `btn_release` pulses for 1 cycle, after edge E(DEB_CYC+3).
- **Repeats.** Repeat pulses occur HOLD_CYC cycles after the press pulse, then every REP_CYC cycles, for as long as the state remains HELD.
- **Glitch rejection.** Any sample of the opposite level during a debounce window restarts the process: DEB_PRESS falls back to IDLE, and DEB_REL returns to HELD.
- **Throughput.** At most one pulse per channel per cycle. There is no backpressure.

## Test plan

All scenarios use DEB_CYC=4, HOLD_CYC=8, REP_CYC=3, REPEAT_EN=1 unless stated.

1. **Clean press.** `btn_raw[1]` rises and is held 20 cycles → `btn_press[1]`=1 for exactly the cycle after E7; `btn_level[1]`=1 from that cycle; other bits stay 0.
2. **Bouncing press.** Raw pattern 1,1,0,1,1,1,1… → single `btn_press` 7 edges after the last 0→1 sample; no earlier pulse; `btn_level` stays 0 until then.
3. **Hold-repeat.** Held for 40 cycles → press pulse at cycle P, repeat pulses at P+8, P+11, P+14, and so on. With REPEAT_EN=0 → only the pulse at P.
4. **Bouncing release.** Raw pattern 0,1,0,0,0,0… after a long hold → one `btn_release` 7 edges after the last 1→0 sample; `btn_level` falls in the same cycle; no press or repeat pulse during the bounce.
5. **Reset mid-hold.** `rst_n` is asserted low while the channel is in HELD → all outputs 0 within the same cycle, asynchronously. Release `rst_n` with the button still held → a new `btn_press` 7 edges after the first sampling edge.
6. **Simultaneous channels.** Bits 0 and 4 rise on the same cycle → both `btn_press` bits pulse in the same cycle; bit 4 glitching for 1 cycle alone produces no pulse.

Source files
------------

// File: rtl/btn_debouncer_if.sv
// Button bundle between the raw pins and the debouncer: raw levels in, clean
// levels and press/release pulses out.
interface btn_debouncer_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (output btn_raw, input btn_level, input btn_press, input btn_release);
    modport slave  (input btn_raw, output btn_level, output btn_press, output btn_release);
endinterface

// File: rtl/btn_debouncer.sv
// Per-channel 2-FF synchroniser plus debounce FSM producing a clean level,
// press pulses (with optional hold-to-repeat) and release pulses.
module btn_debouncer #(
    parameter int N_BTN     = 5,
    parameter int DEB_CYC   = 1048576,
    parameter int HOLD_CYC  = 50000000,
    parameter int REP_CYC   = 10000000,
    parameter int REPEAT_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    btn_debouncer_if.slave  bus
);
    localparam int CW   = $clog2(DEB_CYC);
    localparam int RMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DEB_PRESS = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;
    localparam logic [1:0] DEB_REL   = 2'd3;

    logic [N_BTN-1:0]         sync_p0;
    logic [N_BTN-1:0]         sync_p1;
    logic [N_BTN-1:0][1:0]    state;
    logic [N_BTN-1:0][CW-1:0] cnt;
    logic [N_BTN-1:0][RW-1:0] rcnt;
    logic [N_BTN-1:0]         first_done;
    logic [N_BTN-1:0]         level_q;
    logic [N_BTN-1:0]         press_q;
    logic [N_BTN-1:0]         release_q;

    // Stage p0 -> p1: metastability guard on the asynchronous pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p1 -> outputs: the level is updated on the same edge as the state
    // change so it always reflects HELD/DEB_REL without a combinational decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= '0;
            cnt        <= '0;
            rcnt       <= '0;
            first_done <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;
                case (state[i])
                    IDLE: begin
                        if (sync_p1[i]) begin
                            state[i] <= DEB_PRESS;
                            cnt[i]   <= '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (!sync_p1[i]) begin
                            state[i] <= IDLE;
                        end else if (cnt[i] == CW'(DEB_CYC - 1)) begin
                            state[i]      <= HELD;
                            rcnt[i]       <= '0;
                            first_done[i] <= 1'b0;
                            press_q[i]    <= 1'b1;
                            level_q[i]    <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sync_p1[i]) begin
                            state[i] <= DEB_REL;
                            cnt[i]   <= '0;
                        end else if (REPEAT_EN != 0) begin
                            // First repeat waits HOLD_CYC, later ones REP_CYC
                            if ((!first_done[i] && rcnt[i] == RW'(HOLD_CYC - 1)) ||
                                ( first_done[i] && rcnt[i] == RW'(REP_CYC - 1))) begin
                                press_q[i]    <= 1'b1;
                                rcnt[i]       <= '0;
                                first_done[i] <= 1'b1;
                            end else begin
                                rcnt[i] <= rcnt[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (sync_p1[i]) begin
                            state[i]      <= HELD;
                            rcnt[i]       <= '0;
                            first_done[i] <= 1'b0;
                        end else if (cnt[i] == CW'(DEB_CYC - 1)) begin
                            state[i]     <= IDLE;
                            release_q[i] <= 1'b1;
                            level_q[i]   <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
endmodule

// File: tb/tb_btn_debouncer.sv
// Scoreboard bench for btn_debouncer: stimulus queues expected pulse events,
// monitors pop and compare whenever a press or release pulse appears.
module tb_btn_debouncer;
    typedef struct {
        int         at;
        logic [4:0] p;
        logic [4:0] r;
        logic [4:0] l;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] raw;
    int         cyc;
    int         checks;
    int         failures;
    ev_t        q_rep[$];
    ev_t        q_norep[$];

    btn_debouncer_if #(.N_BTN(5)) bus   ();
    btn_debouncer_if #(.N_BTN(5)) bus_n ();

    assign bus.btn_raw   = raw;
    assign bus_n.btn_raw = raw;

    btn_debouncer #(.N_BTN(5), .DEB_CYC(4), .HOLD_CYC(8), .REP_CYC(3), .REPEAT_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    btn_debouncer #(.N_BTN(5), .DEB_CYC(4), .HOLD_CYC(8), .REP_CYC(3), .REPEAT_EN(0)) dut_norep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t ev;
        if ((bus.btn_press | bus.btn_release) != 5'b0) begin
            checks++;
            if (q_rep.size() == 0) begin
                failures++;
                $display("FAIL rep_unexpected cyc=%0d press=%b release=%b level=%b, required no pulse",
                         cyc, bus.btn_press, bus.btn_release, bus.btn_level);
            end else begin
                ev = q_rep.pop_front();
                if (ev.at != cyc || ev.p != bus.btn_press || ev.r != bus.btn_release || ev.l != bus.btn_level) begin
                    failures++;
                    $display("FAIL rep_event got cyc=%0d press=%b release=%b level=%b, required cyc=%0d press=%b release=%b level=%b",
                             cyc, bus.btn_press, bus.btn_release, bus.btn_level, ev.at, ev.p, ev.r, ev.l);
                end
            end
        end
    end

    always @(negedge clk) begin
        ev_t ev;
        if ((bus_n.btn_press | bus_n.btn_release) != 5'b0) begin
            checks++;
            if (q_norep.size() == 0) begin
                failures++;
                $display("FAIL norep_unexpected cyc=%0d press=%b release=%b level=%b, required no pulse",
                         cyc, bus_n.btn_press, bus_n.btn_release, bus_n.btn_level);
            end else begin
                ev = q_norep.pop_front();
                if (ev.at != cyc || ev.p != bus_n.btn_press || ev.r != bus_n.btn_release || ev.l != bus_n.btn_level) begin
                    failures++;
                    $display("FAIL norep_event got cyc=%0d press=%b release=%b level=%b, required cyc=%0d press=%b release=%b level=%b",
                             cyc, bus_n.btn_press, bus_n.btn_release, bus_n.btn_level, ev.at, ev.p, ev.r, ev.l);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_both(input int at, input logic [4:0] p, input logic [4:0] r, input logic [4:0] l);
        q_rep.push_back('{at, p, r, l});
        q_norep.push_back('{at, p, r, l});
    endtask

    task automatic exp_rep(input int at, input logic [4:0] p, input logic [4:0] r, input logic [4:0] l);
        q_rep.push_back('{at, p, r, l});
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, act, req);
        end
    endtask

    initial begin
        int c;
        int r;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        raw      = 5'b0;
        idle(3);
        chk("reset_level",   bus.btn_level,   5'b0);
        chk("reset_press",   bus.btn_press,   5'b0);
        chk("reset_release", bus.btn_release, 5'b0);
        rst_n = 1'b1;
        idle(2);

        // Clean press on U held 20 cycles
        c = cyc;
        raw = 5'b00010;
        exp_both(c + 7, 5'b00010, 5'b0, 5'b00010);
        exp_rep(c + 15, 5'b00010, 5'b0, 5'b00010);
        exp_rep(c + 18, 5'b00010, 5'b0, 5'b00010);
        exp_rep(c + 21, 5'b00010, 5'b0, 5'b00010);
        idle(20);
        raw = 5'b0;
        exp_both(c + 27, 5'b0, 5'b00010, 5'b0);
        idle(12);

        // Bouncing press on D: 1,1,0,1,1,...
        c = cyc;
        raw = 5'b00100;
        idle(2);
        raw = 5'b0;
        idle(1);
        raw = 5'b00100;
        exp_both(c + 10, 5'b00100, 5'b0, 5'b00100);
        idle(9);
        raw = 5'b0;
        exp_both(c + 19, 5'b0, 5'b00100, 5'b0);
        idle(12);

        // Hold-repeat on L for 40 cycles
        c = cyc;
        raw = 5'b01000;
        exp_both(c + 7, 5'b01000, 5'b0, 5'b01000);
        for (int t = c + 15; t <= c + 42; t += 3) exp_rep(t, 5'b01000, 5'b0, 5'b01000);
        idle(40);
        raw = 5'b0;
        exp_both(c + 47, 5'b0, 5'b01000, 5'b0);
        idle(12);

        // Bouncing release on C: 0,1,0,0,...
        c = cyc;
        raw = 5'b00001;
        exp_both(c + 7, 5'b00001, 5'b0, 5'b00001);
        exp_rep(c + 15, 5'b00001, 5'b0, 5'b00001);
        exp_rep(c + 18, 5'b00001, 5'b0, 5'b00001);
        idle(17);
        raw = 5'b0;
        idle(1);
        raw = 5'b00001;
        idle(1);
        raw = 5'b0;
        exp_both(c + 26, 5'b0, 5'b00001, 5'b0);
        idle(14);

        // Asynchronous reset while held, button still down afterwards
        c = cyc;
        raw = 5'b00010;
        exp_both(c + 7, 5'b00010, 5'b0, 5'b00010);
        idle(10);
        chk("held_level", bus.btn_level, 5'b00010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level",       bus.btn_level,   5'b0);
        chk("async_rst_norep_level", bus_n.btn_level, 5'b0);
        chk("async_rst_press",       bus.btn_press,   5'b0);
        idle(3);
        rst_n = 1'b1;
        r = cyc;
        exp_both(r + 7, 5'b00010, 5'b0, 5'b00010);
        idle(9);
        raw = 5'b0;
        exp_both(r + 16, 5'b0, 5'b00010, 5'b0);
        idle(12);

        // C and R together, then R glitches of 1 and 4 cycles, then a 5-cycle press
        c = cyc;
        raw = 5'b10001;
        exp_both(c + 7, 5'b10001, 5'b0, 5'b10001);
        idle(10);
        raw = 5'b0;
        exp_both(c + 17, 5'b0, 5'b10001, 5'b0);
        idle(12);
        raw = 5'b10000;
        idle(1);
        raw = 5'b0;
        idle(10);
        raw = 5'b10000;
        idle(4);
        raw = 5'b0;
        idle(10);
        c = cyc;
        raw = 5'b10000;
        idle(5);
        raw = 5'b0;
        exp_both(c + 7, 5'b10000, 5'b0, 5'b10000);
        exp_both(c + 12, 5'b0, 5'b10000, 5'b0);
        idle(12);

        checks++;
        if (q_rep.size() != 0) begin
            failures++;
            $display("FAIL rep_missing pending=%0d required=0", q_rep.size());
        end
        checks++;
        if (q_norep.size() != 0) begin
            failures++;
            $display("FAIL norep_missing pending=%0d required=0", q_norep.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
